// File: rtl/rect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rect_pkg
// Brief    : Rectangle geometry and scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rect_pkg;

    localparam int RECT_WIDTH  = 48;
    localparam int RECT_HEIGHT = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } rect_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Screen geometry shared by the display pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int HOR_PIXELS = 640;
    localparam int VER_PIXELS = 480;

endpackage
`default_nettype wire

// File: rtl/rect_pos_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : rect_pos_sched_if
// Brief    : Position-source / draw-stage bundle around the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface rect_pos_sched_if #(
    parameter int NREQ = 3
);
    logic                      vblank_start;
    logic [NREQ-1:0]           req;
    logic [NREQ-1:0][11:0]     req_xpos;
    logic [NREQ-1:0][11:0]     req_ypos;
    logic [NREQ-1:0]           gnt;
    logic [11:0]               xpos;
    logic [11:0]               ypos;
    logic                      frame_upd;

    modport master (
        output vblank_start, req, req_xpos, req_ypos,
        input  gnt, xpos, ypos, frame_upd
    );

    modport slave (
        input  vblank_start, req, req_xpos, req_ypos,
        output gnt, xpos, ypos, frame_upd
    );
endinterface
`default_nettype wire

// File: rtl/rect_pos_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting at a given index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [IW-1:0]   start,
    output logic      [NREQ-1:0] pick,
    output logic                 valid
);
    localparam logic [IW:0] c_nreq = (IW+1)'(NREQ);

    logic [IW:0] w_idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        w_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Walk the ring from the start index, wrapping past the top.
            w_idx = {1'b0, start} + (IW+1)'(i);
            if (w_idx >= c_nreq) begin
                w_idx = w_idx - c_nreq;
            end
            if (!valid && req[w_idx[IW-1:0]]) begin
                pick[w_idx[IW-1:0]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rect_pos_sched.sv
`default_nettype none
// ============================================================================
// Module   : rect_pos_sched
// Brief    : Frame-synchronous owner scheduler for the rectangle position.
// Revision : 1.0 - initial release
// ============================================================================
module rect_pos_sched
    import rect_pkg::*;
    import vga_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter int HOLD_FRAMES    = 4,
    parameter int TIMEOUT_FRAMES = 60
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    rect_pos_sched_if.slave     bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [HW-1:0]   c_hold     = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0]   c_timeout  = HW'(TIMEOUT_FRAMES);
    localparam logic [IW-1:0]   c_last_idx = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] c_top      = NREQ'(1);
    localparam logic [11:0]     c_xmax     = 12'(HOR_PIXELS - RECT_WIDTH);
    localparam logic [11:0]     c_ymax     = 12'(VER_PIXELS - RECT_HEIGHT);

    rect_sched_state_t r_state, w_state_nxt;
    logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
    logic [HW-1:0]     r_held, w_held_nxt;
    logic [IW-1:0]     r_last_owner;
    logic [11:0]       r_xpos, r_ypos;
    logic              r_frame_upd;

    logic              w_commit;
    logic              w_new_grant;
    logic [IW-1:0]     w_start;
    logic [NREQ-1:0]   w_arb_pick;
    logic              w_arb_valid;
    logic [IW-1:0]     w_new_owner;
    logic [11:0]       w_sel_x, w_sel_y;

    // The current owner's request is masked so one arbiter serves both the
    // idle/release pick and the timeout rotation.
    assign w_start = (r_last_owner == c_last_idx) ? '0 : r_last_owner + 1'b1;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req   (bus.req & ~r_gnt),
        .start (w_start),
        .pick  (w_arb_pick),
        .valid (w_arb_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_held_nxt  = r_held;
        w_commit    = 1'b0;
        w_new_grant = 1'b0;
        if (bus.vblank_start) begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        w_gnt_nxt   = w_arb_pick;
                        w_new_grant = 1'b1;
                    end
                end
                OWNED: begin
                    if ((bus.req & r_gnt) == '0) begin
                        if (w_arb_valid) begin
                            w_gnt_nxt   = w_arb_pick;
                            w_new_grant = 1'b1;
                        end else begin
                            w_gnt_nxt   = '0;
                            w_state_nxt = IDLE;
                        end
                    end else if (bus.req[0] && !r_gnt[0] && (r_held >= c_hold)) begin
                        w_gnt_nxt   = c_top;
                        w_new_grant = 1'b1;
                    end else if ((r_held >= c_timeout) && w_arb_valid) begin
                        w_gnt_nxt   = w_arb_pick;
                        w_new_grant = 1'b1;
                    end else begin
                        w_commit = 1'b1;
                        if (r_held < c_timeout) begin
                            w_held_nxt = r_held + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            endcase
            if (w_new_grant) begin
                w_state_nxt = OWNED;
                w_held_nxt  = HW'(1);
                w_commit    = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_x     = '0;
        w_sel_y     = '0;
        w_new_owner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_nxt[i]) begin
                w_sel_x     = bus.req_xpos[i];
                w_sel_y     = bus.req_ypos[i];
                w_new_owner = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_held       <= '0;
            r_last_owner <= c_last_idx;
            r_xpos       <= '0;
            r_ypos       <= '0;
            r_frame_upd  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_held      <= w_held_nxt;
            r_frame_upd <= w_commit;
            if (w_new_grant) begin
                r_last_owner <= w_new_owner;
            end
            if (w_commit) begin
                r_xpos <= (w_sel_x > c_xmax) ? c_xmax : w_sel_x;
                r_ypos <= (w_sel_y > c_ymax) ? c_ymax : w_sel_y;
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.xpos      = r_xpos;
    assign bus.ypos      = r_ypos;
    assign bus.frame_upd = r_frame_upd;

endmodule
`default_nettype wire

// File: tb/tb_rect_pos_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_pos_sched
// Brief    : Directed self-checking bench for rect_pos_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_pos_sched;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rect_pos_sched_if #(.NREQ(3)) bus ();

    rect_pos_sched #(
        .NREQ           (3),
        .HOLD_FRAMES    (4),
        .TIMEOUT_FRAMES (60)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic vblank_pulse();
        @(negedge clk);
        bus.vblank_start = 1'b1;
        @(negedge clk);
        bus.vblank_start = 1'b0;
    endtask

    task automatic set_pos(input int idx, input logic [11:0] x, input logic [11:0] y);
        bus.req_xpos[idx] = x;
        bus.req_ypos[idx] = y;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
        n_checks++;
        if (bus.xpos !== 12'd0 || bus.ypos !== 12'd0) begin
            n_fail++; $display("FAIL reset_pos: got %0d,%0d want 0,0", bus.xpos, bus.ypos);
        end
        n_checks++;
        if (bus.frame_upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b want 0", bus.frame_upd); end
    endtask

    task automatic test_first_grant();
        set_pos(0, 12'd5, 12'd6);
        set_pos(1, 12'd100, 12'd200);
        set_pos(2, 12'd300, 12'd50);
        bus.req = 3'b110;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.frame_upd !== 1'b0) begin
            n_fail++; $display("FAIL no_pulse_frozen: gnt %b upd %b want 000 0", bus.gnt, bus.frame_upd);
        end
        vblank_pulse();
        n_checks++;
        if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL first_gnt: got %b want 010", bus.gnt); end
        n_checks++;
        if (bus.xpos !== 12'd100 || bus.ypos !== 12'd200) begin
            n_fail++; $display("FAIL first_pos: got %0d,%0d want 100,200", bus.xpos, bus.ypos);
        end
        n_checks++;
        if (bus.frame_upd !== 1'b1) begin n_fail++; $display("FAIL first_upd: got %b want 1", bus.frame_upd); end
        // Inputs moving between pulses must not leak through.
        set_pos(1, 12'd111, 12'd222);
        bus.req = 3'b111;
        @(negedge clk);
        n_checks++;
        if (bus.frame_upd !== 1'b0 || bus.gnt !== 3'b010 || bus.xpos !== 12'd100) begin
            n_fail++;
            $display("FAIL first_single_pulse: upd %b gnt %b x %0d want 0 010 100", bus.frame_upd, bus.gnt, bus.xpos);
        end
    endtask

    task automatic test_preempt();
        bus.req = 3'b010;
        set_pos(0, 12'd700, 12'd100);
        vblank_pulse();
        bus.req = 3'b011;
        for (int f = 0; f < 2; f++) begin
            vblank_pulse();
            n_checks++;
            if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL preempt_hold%0d: got %b want 010", f, bus.gnt); end
        end
        vblank_pulse();
        n_checks++;
        if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL preempt_gnt: got %b want 001", bus.gnt); end
        n_checks++;
        if (bus.xpos !== 12'd592 || bus.ypos !== 12'd100 || bus.frame_upd !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_pos: got %0d,%0d upd %b want 592,100 1", bus.xpos, bus.ypos, bus.frame_upd);
        end
    endtask

    task automatic test_release_rearb();
        set_pos(2, 12'd150, 12'd250);
        bus.req = 3'b100;
        vblank_pulse();
        n_checks++;
        if (bus.gnt !== 3'b100 || bus.xpos !== 12'd150 || bus.ypos !== 12'd250 || bus.frame_upd !== 1'b1) begin
            n_fail++;
            $display("FAIL release_rearb: gnt %b pos %0d,%0d upd %b want 100 150,250 1",
                     bus.gnt, bus.xpos, bus.ypos, bus.frame_upd);
        end
    endtask

    task automatic test_release_idle();
        set_pos(2, 12'd9, 12'd9);
        bus.req = 3'b000;
        @(negedge clk);
        bus.vblank_start = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.frame_upd !== 1'b0) begin n_fail++; $display("FAIL idle_upd: got %b want 0", bus.frame_upd); end
        @(negedge clk);
        bus.vblank_start = 1'b0;
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.xpos !== 12'd150 || bus.ypos !== 12'd250) begin
            n_fail++;
            $display("FAIL idle_state: gnt %b pos %0d,%0d want 000 150,250", bus.gnt, bus.xpos, bus.ypos);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        set_pos(2, 12'd40, 12'd41);
        set_pos(1, 12'd42, 12'd43);
        bus.req = 3'b100;
        vblank_pulse();
        n_checks++;
        if (bus.gnt !== 3'b100) begin n_fail++; $display("FAIL timeout_start: got %b want 100", bus.gnt); end
        bus.req = 3'b110;
        for (int f = 1; f < 60; f++) begin
            vblank_pulse();
            if (bus.gnt !== 3'b100 && early == 0) early = f;
        end
        n_checks++;
        if (early != 0) begin n_fail++; $display("FAIL timeout_early: rotated at frame %0d want 60", early); end
        vblank_pulse();
        n_checks++;
        if (bus.gnt !== 3'b010 || bus.xpos !== 12'd42 || bus.ypos !== 12'd43) begin
            n_fail++;
            $display("FAIL timeout_rotate: gnt %b pos %0d,%0d want 010 42,43", bus.gnt, bus.xpos, bus.ypos);
        end
    endtask

    task automatic test_clamp();
        logic [11:0] xs [3];
        logic [11:0] ys [3];
        logic [11:0] ex [3];
        logic [11:0] ey [3];
        xs = '{12'd700, 12'd591, 12'd592};
        ys = '{12'd590, 12'd416, 12'd417};
        ex = '{12'd592, 12'd591, 12'd592};
        ey = '{12'd416, 12'd416, 12'd416};
        bus.req = 3'b010;
        for (int v = 0; v < 3; v++) begin
            set_pos(1, xs[v], ys[v]);
            vblank_pulse();
            n_checks++;
            if (bus.xpos !== ex[v] || bus.ypos !== ey[v]) begin
                n_fail++;
                $display("FAIL clamp%0d: got %0d,%0d want %0d,%0d", v, bus.xpos, bus.ypos, ex[v], ey[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_pos(1, 12'd10, 12'd20);
        @(negedge clk);
        bus.vblank_start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.xpos !== 12'd10 || bus.frame_upd !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: x %0d upd %b want 10 1", bus.xpos, bus.frame_upd);
        end
        set_pos(1, 12'd30, 12'd40);
        @(negedge clk);
        bus.vblank_start = 1'b0;
        n_checks++;
        if (bus.xpos !== 12'd30 || bus.ypos !== 12'd40 || bus.frame_upd !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: pos %0d,%0d upd %b want 30,40 1", bus.xpos, bus.ypos, bus.frame_upd);
        end
        @(negedge clk);
        n_checks++;
        if (bus.frame_upd !== 1'b0) begin n_fail++; $display("FAIL b2b_end: upd %b want 0", bus.frame_upd); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.xpos !== 12'd0 || bus.ypos !== 12'd0 || bus.frame_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: gnt %b pos %0d,%0d upd %b want 000 0,0 0",
                     bus.gnt, bus.xpos, bus.ypos, bus.frame_upd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_pos(0, 12'd11, 12'd12);
        bus.req = 3'b111;
        vblank_pulse();
        n_checks++;
        if (bus.gnt !== 3'b001 || bus.xpos !== 12'd11 || bus.ypos !== 12'd12) begin
            n_fail++;
            $display("FAIL reset_regrant: gnt %b pos %0d,%0d want 001 11,12", bus.gnt, bus.xpos, bus.ypos);
        end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus.vblank_start = 1'b0;
        bus.req          = '0;
        bus.req_xpos     = '0;
        bus.req_ypos     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_first_grant();
        test_preempt();
        test_release_rearb();
        test_release_idle();
        test_timeout();
        test_clamp();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
